itcm_port_arbiter: RTL

- Shares the single-port, synchronous-read ITCM (1-cycle read latency) between two requesters: instruction fetch and a data-side port (LSU accesses to ITCM, program loader).
- Drives the ITCM address, write and byte-enable lines.
- Generates the PC-hold and IF/ID-hold stall signals the fetch unit needs whenever the data side owns the port.
- Bounds fetch starvation with a programmable counter.

---
 rtl/itcm_port_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/itcm_port_arbiter.sv
// Arbitrates the single-port ITCM between instruction fetch and the data side,
// with bounded fetch starvation. Define ITCM_ARB_PERF_EN to add performance counters.
module itcm_port_arbiter #(
    parameter int ADDR_WTH   = 32,
    parameter int WORD_WTH   = 32,
    parameter int MAX_STARVE = 4,
    parameter int CNT_WTH    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_en_i,
    input  logic [ADDR_WTH-1:0]   ifu_addr_i,
    input  logic                  d_req_i,
    input  logic                  d_we_i,
    input  logic [WORD_WTH/8-1:0] d_be_i,
    input  logic [ADDR_WTH-1:0]   d_addr_i,
    input  logic [WORD_WTH-1:0]   d_wdata_i,
    output logic                  d_gnt_o,
    output logic                  d_rvalid_o,
    output logic [WORD_WTH-1:0]   d_rdata_o,
    output logic                  ifu_stall_pc_o,
    output logic                  ifu_stall_o,
    output logic [ADDR_WTH-1:0]   itcm_addr_o,
    output logic                  itcm_we_o,
    output logic [WORD_WTH/8-1:0] itcm_be_o,
    output logic [WORD_WTH-1:0]   itcm_wdata_o,
    input  logic [WORD_WTH-1:0]   itcm_rdata_i
`ifdef ITCM_ARB_PERF_EN
    ,
    output logic [31:0]           perf_dgrant_cnt_o,
    output logic [31:0]           perf_force_cnt_o
`endif
);

    localparam int BE_WTH = WORD_WTH / 8;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_DATA  = 2'd1,
        S_FORCE = 2'd2
    } state_t;

    state_t               state_reg, state_next;
    logic [CNT_WTH-1:0]   count_reg, count_next, count_inc;
    logic                 at_limit;
    logic                 rd_pend_reg;
    logic                 data_last_reg;
    logic                 gnt_d;

    assign gnt_d = d_req_i && (state_reg != S_FORCE);

    // Saturating increment: the count never wraps back to a small value.
    assign count_inc = (count_reg == {CNT_WTH{1'b1}}) ? count_reg : count_reg + 1'b1;
    assign at_limit  = (count_inc >= CNT_WTH'(MAX_STARVE));

    always_comb begin
        state_next = S_FETCH;
        count_next = '0;
        if (fetch_en_i) begin
            case (state_reg)
                S_FETCH, S_DATA: begin
                    if (gnt_d) begin
                        count_next = count_inc;
                        state_next = at_limit ? S_FORCE : S_DATA;
                    end
                end
                default: begin
                    state_next = S_FETCH;
                    count_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_FETCH;
            count_reg     <= '0;
            rd_pend_reg   <= 1'b0;
            data_last_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            rd_pend_reg   <= gnt_d & ~d_we_i;
            data_last_reg <= gnt_d & fetch_en_i;
        end
    end

    assign itcm_addr_o    = gnt_d ? d_addr_i : ifu_addr_i;
    assign itcm_we_o      = gnt_d & d_we_i;
    assign itcm_wdata_o   = d_wdata_i;

    generate
        for (genvar gi = 0; gi < BE_WTH; gi++) begin : g_be
            assign itcm_be_o[gi] = gnt_d & d_be_i[gi];
        end
    endgenerate

    assign d_gnt_o        = gnt_d;
    assign d_rvalid_o     = rd_pend_reg;
    assign d_rdata_o      = itcm_rdata_i;

    // The ITCM word returned the cycle after a data grant is not an instruction.
    assign ifu_stall_pc_o = gnt_d & fetch_en_i;
    assign ifu_stall_o    = data_last_reg;

`ifdef ITCM_ARB_PERF_EN
    logic [31:0] perf_dgrant_reg;
    logic [31:0] perf_force_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_dgrant_reg <= '0;
            perf_force_reg  <= '0;
        end else begin
            if (gnt_d)
                perf_dgrant_reg <= perf_dgrant_reg + 32'd1;
            if (state_next == S_FORCE)
                perf_force_reg  <= perf_force_reg + 32'd1;
        end
    end

    assign perf_dgrant_cnt_o = perf_dgrant_reg;
    assign perf_force_cnt_o  = perf_force_reg;
`endif

endmodule
